writeback_unit: RTL
===================

# writeback_unit

Parametrised register-file writeback stage with a buffered output-port channel. Sits at the end of the MEM/WB boundary. It selects the writeback value from the ALU, memory or input-port source and issues a registered register-file write. OUT instructions are queued to an external output device over a valid/ready handshake, and the stage back-pressures the pipeline when the queue is full.

## Interface
Parameters:
- DATA_W, 16, datapath width
- RA_W, 3, register address width
- OUT_DEPTH, 4, output queue depth (power of two, ≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  MEM/WB slot holds an instruction
- in_ready  out  1  stage accepts the slot this cycle
- alu_result  in  DATA_W  ALU output
- mem_data  in  DATA_W  memory read data
- in_port  in  DATA_W  sampled input-port value
- mem_sel  in  1  writeback source is memory
- in_sel  in  1  writeback source is input port
- out_sel  in  1  instruction is OUT; alu_result goes to output queue
- reg_write  in  1  instruction writes rd
- rd  in  RA_W  destination register
- rf_we  out  1  register-file write enable
- rf_addr  out  RA_W  register-file write address
- rf_data  out  DATA_W  register-file write data
- out_valid  out  1  queue head is valid
- out_ready  in  1  output device takes head
- out_data  out  DATA_W  queue head
- out_last  out  DATA_W  last value handed to the device
- out_count  out  $clog2(OUT_DEPTH+1)  queue occupancy

## Operation
- Source select, by priority: in_sel → in_port; else mem_sel → mem_data; else alu_result.
- Accept condition: accept = in_valid & in_ready.
- Ready rule: in_ready = ~out_sel | ~full | (out_valid & out_ready). This is combinational and allows the full-queue pass-through case.
- On accept with reg_write: rf_we=1, rf_addr=rd and rf_data=selected value, all registered. Otherwise rf_we=0, and rf_addr/rf_data hold their last value.
- On accept with out_sel: push alu_result to the queue. out_sel and reg_write may both be set; both actions happen on the same accept.
- A non-accepted slot has no side effect: no write and no push. Upstream must hold the slot stable.
- Pop: happens when out_valid & out_ready. On a pop, out_last ← out_data.
- Push and pop in the same cycle: count unchanged. This is legal when full and also when count==1.
- Empty queue: out_valid=0, and out_data reads as don't-care (the implementation drives 0).
- Pointers wrap modulo OUT_DEPTH. count==OUT_DEPTH means full.

## Timing
- Latency:
  - Accept to rf_we/rf_addr/rf_data: 1 cycle.
  - Push to out_valid: 1 cycle. There is no same-cycle bypass from input to out_data.
  - Pop to out_last update: 1 cycle.
- Reset values: rf_we=0, rf_addr=0, rf_data=0, out_valid=0, out_data=0, out_last=0, out_count=0, pointers=0. in_ready reads 1 whenever the queue is not full.
- Reset mid-operation: queued data is discarded. A pending rf write is dropped if rst is asserted before the capturing edge.
- out_valid must not drop without a pop. out_data must stay stable while out_valid & ~out_ready.

## Configuration
- WB_OUT_FIFO_EN defined: the queue has OUT_DEPTH entries as specified above.
- Undefined: the queue is a single holding register (effective depth 1). OUT_DEPTH is ignored and out_count is 0/1. Push while full is accepted only with a simultaneous pop.
- All other behaviour is identical in both modes.

## Structure
- Package wb_pkg:
  - wb_src_e enum: WB_ALU, WB_MEM, WB_IN.
  - Default DATA_W and RA_W constants.
  - Source-select function shared with the forwarding logic.
- Sub-module wb_out_fifo is parametrised on DATA_W and OUT_DEPTH, and contains the push/pop/count logic. Its depth-1 variant is selected by WB_OUT_FIFO_EN.

## Test plan
- Reset: rst pulse mid-stream → all outputs 0, out_count=0, and in_ready=1 on the first cycle after release.
- Source priority:
  - alu_result=0x1111, mem_data=0x2222, in_port=0x3333, reg_write=1, rd=5.
  - Cycle with mem_sel=1 → rf_data=0x2222.
  - Cycle with in_sel=1 and mem_sel=1 → rf_data=0x3333.
  - In each case rf_we=1, rf_addr=5, one cycle later.
- Fill and stall:
  - With out_ready=0, issue 4 OUTs (0xA0..0xA3) → out_count=4.
  - A 5th OUT with reg_write=1 → in_ready=0, no rf_we, held.
  - Raise out_ready → 5th accepted the same cycle, out_count stays 4.
- Drain order: out_ready=1 → out_data sequence 0xA0, 0xA1, 0xA2, 0xA3, then 0xA4. out_last trails by one cycle, and out_valid=0 after the last pop.
- Non-OUT under full queue: with the queue full, issue an ALU instruction with reg_write=1, rd=2 → accepted (in_ready=1), rf_we=1, rf_addr=2, and out_count unchanged.
- Macro off: with WB_OUT_FIFO_EN undefined, two back-to-back OUTs with out_ready=0 → second stalls. out_count never exceeds 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: source encoding, default widths,
// and the source-priority function also used by the forwarding network.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_RA_W   = 3;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_IN  = 2'd2
  } wb_src_e;

  // Input port beats memory, memory beats ALU.
  function automatic wb_src_e wb_src_sel(input logic in_sel, input logic mem_sel);
    if (in_sel) begin
      return WB_IN;
    end else if (mem_sel) begin
      return WB_MEM;
    end
    return WB_ALU;
  endfunction

endpackage

// File: rtl/wb_out_fifo.sv
// Output-port queue between the writeback stage and the external device.
// WB_OUT_FIFO_EN selects an OUT_DEPTH-entry ring buffer; otherwise a single holding register.
module wb_out_fifo #(
  parameter int DATA_W    = 16,
  parameter int OUT_DEPTH = 4,
  localparam int CNT_W    = $clog2(OUT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o
);

`ifdef WB_OUT_FIFO_EN
  localparam int PTR_W = $clog2(OUT_DEPTH);

  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              pop;

  assign valid_o = (count_q != '0);
  assign pop     = valid_o & ready_i;
  assign full_o  = (count_q == CNT_W'(OUT_DEPTH));
  assign count_o = count_q;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; out_data is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end
`else
  logic [DATA_W-1:0] data_q;
  logic              vld_q;
  logic              pop;

  assign valid_o = vld_q;
  assign pop     = vld_q & ready_i;
  assign full_o  = vld_q;
  assign count_o = {{(CNT_W-1){1'b0}}, vld_q};
  assign data_o  = vld_q ? data_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else if (push_i) begin
      vld_q <= 1'b1;
    end else if (pop) begin
      vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) data_q <= push_data_i;
  end
`endif

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback stage with a buffered OUT channel and back-pressure.
// Queue depth follows WB_OUT_FIFO_EN (see wb_out_fifo).
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W    = WB_DATA_W,
  parameter int RA_W      = WB_RA_W,
  parameter int OUT_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              alu_result,
  input  logic [DATA_W-1:0]              mem_data,
  input  logic [DATA_W-1:0]              in_port,
  input  logic                           mem_sel,
  input  logic                           in_sel,
  input  logic                           out_sel,
  input  logic                           reg_write,
  input  logic [RA_W-1:0]                rd,
  output logic                           rf_we,
  output logic [RA_W-1:0]                rf_addr,
  output logic [DATA_W-1:0]              rf_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [DATA_W-1:0]              out_last,
  output logic [$clog2(OUT_DEPTH+1)-1:0] out_count
);

  wb_src_e           src;
  logic [DATA_W-1:0] rf_data_d;
  logic              rf_we_q;
  logic [RA_W-1:0]   rf_addr_q;
  logic [DATA_W-1:0] rf_data_q;
  logic [DATA_W-1:0] out_last_q;
  logic              full;
  logic              pop;
  logic              accept;

  always_comb begin
    src = wb_src_sel(in_sel, mem_sel);
    case (src)
      WB_IN:   rf_data_d = in_port;
      WB_MEM:  rf_data_d = mem_data;
      default: rf_data_d = alu_result;
    endcase
  end

  // A full queue still accepts an OUT when the head leaves in the same cycle.
  assign pop      = out_valid & out_ready;
  assign in_ready = ~out_sel | ~full | pop;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_data_q  <= '0;
      out_last_q <= '0;
    end else begin
      rf_we_q <= accept & reg_write;
      if (accept & reg_write) begin
        rf_addr_q <= rd;
        rf_data_q <= rf_data_d;
      end
      if (pop) out_last_q <= out_data;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_data  = rf_data_q;
  assign out_last = out_last_q;

  wb_out_fifo #(
    .DATA_W    (DATA_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept & out_sel),
    .push_data_i (alu_result),
    .ready_i     (out_ready),
    .valid_o     (out_valid),
    .data_o      (out_data),
    .count_o     (out_count),
    .full_o      (full)
  );

endmodule
